// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, WIDTH cycles per quotient.
// result = {remainder, quotient}; DIV uses magnitudes with signs reapplied at completion.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n, a_abs, b_abs;
  logic [WIDTH:0] shifted, diff;
  logic q_neg, r_neg;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    a_abs   = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    b_abs   = (signed_div && divisor[WIDTH-1]) ? -divisor : divisor;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start && !cancel) nxt = (divisor == '0) ? DIVZERO : ON;
      DIVZERO: nxt = cancel ? IDLE : END;
      ON:      nxt = cancel ? IDLE : ((cnt == LAST) ? END : ON);
      END:     nxt = (cancel || !start) ? IDLE : END;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= nxt;
      ready <= (nxt == END);
      busy  <= (nxt == DIVZERO) || (nxt == ON);
      if (state == IDLE && nxt != IDLE) begin
        rem   <= '0;
        quo   <= a_abs;
        dvs   <= b_abs;
        cnt   <= '0;
        q_neg <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg <= signed_div && dividend[WIDTH-1];
      end
      if (state == ON) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
      end
      // a cancel on the completion edge leaves result untouched
      if (state == ON && nxt == END)
        result <= {r_neg ? -rem_n : rem_n, q_neg ? -quo_n : quo_n};
      if (state == DIVZERO && nxt == END)
        result <= '0;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors plus cancel, hold, reset corner sequences for div_unit.
module tb_div_unit;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, signed_div = 1'b0, cancel = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [63:0] result;
  logic ready, busy;
  int n_vec = 0, n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div), .cancel(cancel),
    .dividend(dividend), .divisor(divisor), .result(result), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] e, input int hold);
    int n, bc, lat;
    start = 1'b1; signed_div = s; dividend = a; divisor = b;
    @(negedge clk);
    dividend = ~a; divisor = b + 32'd1; signed_div = ~s;
    n = 1;
    bc = busy ? 1 : 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    lat = (b == 32'd0) ? 1 : 32;
    chk({nm, " latency"}, 65'(n - 1), 65'(lat));
    chk({nm, " busy cycles"}, 65'(bc), 65'(lat));
    chk({nm, " result"}, {1'b0, result}, {1'b0, e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " held in END"}, {ready, result}, {1'b1, e});
    end
    start = 1'b0;
    @(negedge clk);
    chk({nm, " idle after drop"}, {63'd0, busy, ready}, 65'd0);
  endtask

  initial begin
    logic [63:0] prev;
    int n, hits;
    vecs[0]  = '{"divu 100/7",      1'b0, 32'd100,       32'd7,        {32'd2, 32'd14}};
    vecs[1]  = '{"div -7/2",        1'b1, 32'hFFFFFFF9,  32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{"div 7/-2",        1'b1, 32'd7,         32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}};
    vecs[3]  = '{"div 5/0",         1'b1, 32'd5,         32'd0,        64'd0};
    vecs[4]  = '{"div -100/7",      1'b1, 32'hFFFFFF9C,  32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2}};
    vecs[5]  = '{"div ovf",         1'b1, 32'h80000000,  32'hFFFFFFFF, {32'd0, 32'h80000000}};
    vecs[6]  = '{"divu ovf ops",    1'b0, 32'h80000000,  32'hFFFFFFFF, {32'h80000000, 32'd0}};
    vecs[7]  = '{"divu 3/5",        1'b0, 32'd3,         32'd5,        {32'd3, 32'd0}};
    vecs[8]  = '{"divu 0/5",        1'b0, 32'd0,         32'd5,        64'd0};
    vecs[9]  = '{"divu max/1",      1'b0, 32'hFFFFFFFF,  32'd1,        {32'd0, 32'hFFFFFFFF}};
    vecs[10] = '{"div -8/-3",       1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD, {32'hFFFFFFFE, 32'd2}};
    repeat (2) @(negedge clk);
    chk("reset outputs", {result, ready}, 65'd0);
    chk("reset busy", {64'd0, busy}, 65'd0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 3 : 0);

    // cancel during iteration 10: no ready, result keeps its last value
    prev = result;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (11) @(negedge clk);
    chk("busy before cancel", {64'd0, busy}, 65'd1);
    cancel = 1'b1; start = 1'b0;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel to idle", {63'd0, busy, ready}, 65'd0);
    hits = 0;
    repeat (40) begin @(negedge clk); if (ready) hits++; end
    chk("no ready after cancel", 65'(hits), 65'd0);
    chk("result kept on cancel", {1'b0, result}, {1'b0, prev});
    run("divu max/16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 0);

    // cancel arriving together with the completion edge
    prev = result;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    n = 0;
    repeat (32) @(negedge clk);
    chk("still busy before last edge", {63'd0, busy, ready}, 65'd2);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    chk("cancel wins at completion", {63'd0, busy, ready}, 65'd0);
    chk("result kept at completion cancel", {1'b0, result}, {1'b0, prev});
    @(negedge clk);

    // cancel in IDLE blocks acceptance
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
    repeat (3) @(negedge clk);
    chk("cancel blocks accept", {63'd0, busy, ready}, 65'd0);
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);

    // asynchronous reset mid-division
    run("divu 50/7", 1'b0, 32'd50, 32'd7, {32'd1, 32'd7}, 0);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1234; divisor = 32'd5;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk("async reset", {result, ready}, 65'd0);
    chk("async reset busy", {64'd0, busy}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run("divu 9/3 after reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
